uart_loader: RTL and testbench
==============================

# uart_loader

Byte-stream command decoder sitting behind the UART's receive FIFO and in front of the core's instruction/data memory write port. Pops received bytes, parses a small framed loader protocol (WRITE words to memory, JUMP to an entry address), performs memory writes with a valid/ready handshake and answers each frame with a one-byte response through the UART transmit FIFO. Used as the boot path: the host streams a program image, then issues JUMP to release the core.

## Interface
- CMD_WRITE, 8'h57, command byte for a memory write frame
- CMD_JUMP, 8'h4A, command byte for a jump frame
- Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset; one clock domain
- rx_data  in  8  byte from UART RX FIFO, valid when rx_ack=1
- rx_pop  out  1  single-cycle request to pop one RX byte
- rx_ack  in  1  pulses one cycle after an accepted rx_pop, qualifies rx_data
- tx_data  out  8  response byte
- tx_available  out  1  response byte valid, held until tx_ack
- tx_ack  in  1  UART accepted tx_data this cycle
- mem_valid  out  1  write request, held until mem_ready
- mem_addr  out  32  word-aligned byte address (bits[1:0]=0)
- mem_wdata  out  32  write data
- mem_ready  in  1  write accepted when mem_valid&mem_ready
- boot_valid  out  1  one-cycle pulse: jump accepted
- boot_addr  out  32  jump target, held until next accepted JUMP
- busy  out  1  high whenever state != IDLE

## Operation
- Byte fetch: in a state needing a byte, pulse rx_pop one cycle, then wait one cycle; rx_ack in the wait cycle -> consume rx_data, else re-pulse. Never two pops in consecutive cycles.
- Frame WRITE: CMD_WRITE, addr[31:0] (4 bytes LE), count (1 byte, 0 means 256 words), count×4 data bytes (LE per word), [checksum].
- Frame JUMP: CMD_JUMP, addr[31:0] (4 bytes LE), [checksum].
- States: IDLE -> ADDR (byte idx 0..3) -> WRITE: COUNT -> DATA (byte idx 0..3) -> MEMW -> (DATA | CKSUM) -> RESP -> IDLE. JUMP: ADDR -> CKSUM -> RESP -> IDLE.
- IDLE: fetch byte; CMD_WRITE/CMD_JUMP -> ADDR; any other byte -> RESP with 8'h3F ('?').
- Address bits[1:0] forced to 0. Each completed word: mem_valid with mem_addr, mem_wdata; on handshake address += 4 (wraps mod 2^32), word counter -= 1 (8-bit, 0 loaded as 256 via 9-bit counter).
- Memory writes are not deferred until checksum; host sees NAK and resends.
- Response: 8'h06 ACK on success, 8'h15 NAK on checksum mismatch. JUMP with ACK: boot_addr <= addr, boot_valid pulses the cycle RESP enters.
- Reset values: rx_pop=0, tx_available=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, boot_valid=0, boot_addr=0, busy=0, state IDLE.

## Timing
- Best case one byte per 2 cycles; rx_ack arriving late only stalls.
- mem_valid asserts the cycle after the 4th data byte is consumed; no byte fetch while mem_valid high.
- mem_valid, mem_addr, mem_wdata stable while mem_valid&!mem_ready.
- tx_available asserts on RESP entry, drops the cycle after tx_ack; IDLE re-entered same edge.
- Reset asserted mid-frame: all outputs to reset values immediately (async); partial frame discarded, no response sent.
- rx_ack without a pending pop: ignored.

## Configuration
- UART_LOADER_CKSUM_EN defined: frames carry a trailing checksum byte; required value = 8-bit sum mod 256 of all bytes after the command byte (address, count, data). Mismatch -> NAK, JUMP not taken.
- Undefined: no CKSUM state, no checksum byte expected, response always ACK for WRITE/JUMP.

## Structure
- Package uart_loader_pkg: CMD_WRITE/CMD_JUMP defaults, RESP_ACK/RESP_NAK/RESP_UNK constants, state enum.
- Sub-module uart_rx_reader: pop/wait/re-pop handshake, presents byte_valid/byte_data to the parser FSM on request.

## Test plan
- WRITE addr 0x00001003, count 2, words 0xDEADBEEF, 0x01234567, correct cksum -> mem writes (0x1000, 0xDEADBEEF), (0x1004, 0x01234567); tx 0x06.
- Same frame with cksum+1 (CKSUM_EN) -> both writes still occur; tx 0x15.
- JUMP 0x80000000 valid -> boot_valid one cycle, boot_addr=0x80000000, tx 0x06; bad cksum -> no pulse, tx 0x15.
- Byte 0x00 in IDLE -> tx 0x3F, back to IDLE, next valid frame processed normally.
- mem_ready low 10 cycles, RX FIFO empty gaps, tx_ack delayed 5 cycles -> outputs held stable, no lost or duplicated pops.
- WRITE count 0 at 0xFFFFFC00 -> 256 writes, last address 0xFFFFFFFC; rst_n low mid-data -> outputs reset, no response.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants, state encoding and helpers for the UART boot loader.
// Optional trailing checksum byte is enabled by defining UART_LOADER_CKSUM_EN.
package uart_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned IDX_W  = 2;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_JUMP  = 8'h4A;
  localparam logic [BYTE_W-1:0] RESP_ACK  = 8'h06;
  localparam logic [BYTE_W-1:0] RESP_NAK  = 8'h15;
  localparam logic [BYTE_W-1:0] RESP_UNK  = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_MEMW,
`ifdef UART_LOADER_CKSUM_EN
    ST_CKSUM,
`endif
    ST_RESP
  } state_e;

  // States in which the parser consumes a byte from the RX FIFO.
  function automatic logic needs_byte(input state_e s);
    case (s)
      ST_IDLE, ST_ADDR, ST_COUNT, ST_DATA: return 1'b1;
`ifdef UART_LOADER_CKSUM_EN
      ST_CKSUM: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_reader.sv
// Pop / wait / re-pop handshake against the UART RX FIFO.
// A pop is issued for one cycle, the following cycle is the wait cycle in
// which rx_ack qualifies rx_data; no ack means the pop is simply repeated.
module uart_rx_reader
  import uart_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              want,
  input  logic              rx_ack,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_pop,
  output logic              byte_valid_c,
  output logic [BYTE_W-1:0] byte_data_c
);

  logic wait_q;

  // Pop whenever the parser wants a byte and the previous cycle was not a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pop <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      rx_pop <= want & ~rx_pop;
      wait_q <= rx_pop;
    end
  end

  // rx_ack outside the wait cycle belongs to no pop of ours and is ignored.
  assign byte_valid_c = wait_q & rx_ack;
  assign byte_data_c  = rx_data;

endmodule

// File: rtl/uart_loader.sv
// Framed loader protocol decoder: WRITE words into memory, JUMP to an entry
// address, one response byte per frame. Build option: UART_LOADER_CKSUM_EN
// adds a trailing 8-bit additive checksum byte to every WRITE/JUMP frame.
module uart_loader
  import uart_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_pop,
  input  logic              rx_ack,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_available,
  input  logic              tx_ack,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              boot_valid,
  output logic [ADDR_W-1:0] boot_addr,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               jump_q, jump_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               mem_valid_d;
  logic               tx_available_d;
  logic [BYTE_W-1:0]  tx_data_d;
  logic               boot_valid_d;
  logic [ADDR_W-1:0]  boot_addr_d;
  logic               enter_resp;
  logic               take_boot;
  logic [BYTE_W-1:0]  resp_byte;
`ifdef UART_LOADER_CKSUM_EN
  logic [BYTE_W-1:0]  sum_q, sum_d;
`endif

  logic               want_c;
  logic               byte_valid_c;
  logic [BYTE_W-1:0]  byte_data_c;

  // Request a byte whenever the state being entered consumes one.
  assign want_c = needs_byte(state_d);

  uart_rx_reader u_rx_reader (
    .clk          (clk),
    .rst_n        (rst_n),
    .want         (want_c),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .byte_valid_c (byte_valid_c),
    .byte_data_c  (byte_data_c)
  );

  // State and registered outputs; mem_addr/mem_wdata double as the frame's
  // address and word assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      jump_q       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_valid    <= 1'b0;
      tx_available <= 1'b0;
      tx_data      <= '0;
      boot_valid   <= 1'b0;
      boot_addr    <= '0;
      busy         <= 1'b0;
`ifdef UART_LOADER_CKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      jump_q       <= jump_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      mem_valid    <= mem_valid_d;
      tx_available <= tx_available_d;
      tx_data      <= tx_data_d;
      boot_valid   <= boot_valid_d;
      boot_addr    <= boot_addr_d;
      busy         <= (state_d != ST_IDLE);
`ifdef UART_LOADER_CKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // Frame parser: next state and next output values.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    jump_d         = jump_q;
    addr_d         = mem_addr;
    wdata_d        = mem_wdata;
    mem_valid_d    = mem_valid;
    tx_available_d = tx_available;
    tx_data_d      = tx_data;
    boot_valid_d   = 1'b0;
    boot_addr_d    = boot_addr;
    enter_resp     = 1'b0;
    take_boot      = 1'b0;
    resp_byte      = RESP_ACK;
`ifdef UART_LOADER_CKSUM_EN
    sum_d          = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (byte_valid_c) begin
          if (byte_data_c == CMD_WRITE || byte_data_c == CMD_JUMP) begin
            state_d = ST_ADDR;
            idx_d   = '0;
            jump_d  = (byte_data_c == CMD_JUMP);
          end else begin
            enter_resp = 1'b1;
            resp_byte  = RESP_UNK;
          end
        end
      end

      ST_ADDR: begin
        if (byte_valid_c) begin
          addr_d = {byte_data_c, mem_addr[ADDR_W-1:BYTE_W]};
          idx_d  = IDX_W'(idx_q + 1'b1);
          if (idx_q == IDX_W'(3)) begin
            addr_d[1:0] = 2'b00;
            if (!jump_q) begin
              state_d = ST_COUNT;
            end else begin
`ifdef UART_LOADER_CKSUM_EN
              state_d = ST_CKSUM;
`else
              enter_resp = 1'b1;
              take_boot  = 1'b1;
`endif
            end
          end
        end
      end

      ST_COUNT: begin
        if (byte_valid_c) begin
          cnt_d   = (byte_data_c == 8'h00) ? CNT_W'(256) : CNT_W'(byte_data_c);
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (byte_valid_c) begin
          wdata_d = {byte_data_c, mem_wdata[DATA_W-1:BYTE_W]};
          idx_d   = IDX_W'(idx_q + 1'b1);
          if (idx_q == IDX_W'(3)) begin
            state_d     = ST_MEMW;
            mem_valid_d = 1'b1;
          end
        end
      end

      ST_MEMW: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          addr_d      = ADDR_W'(mem_addr + 32'd4);
          cnt_d       = CNT_W'(cnt_q - 1'b1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef UART_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            enter_resp = 1'b1;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end

`ifdef UART_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (byte_valid_c) begin
          enter_resp = 1'b1;
          if (byte_data_c == sum_q) begin
            take_boot = jump_q;
          end else begin
            resp_byte = RESP_NAK;
          end
        end
      end
`endif

      ST_RESP: begin
        if (tx_ack) begin
          tx_available_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      state_d        = ST_RESP;
      tx_available_d = 1'b1;
      tx_data_d      = resp_byte;
    end

    if (take_boot) begin
      boot_valid_d = 1'b1;
      boot_addr_d  = addr_d;
    end

`ifdef UART_LOADER_CKSUM_EN
    // Running sum restarts at the command byte and covers everything after it.
    if (byte_valid_c) begin
      sum_d = (state_q == ST_IDLE) ? '0 : BYTE_W'(sum_q + byte_data_c);
    end
`endif
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: frames are built as byte lists, the expected
// memory writes / responses / boot targets are derived from the frame contents.
module tb_uart_loader;
  import uart_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_pop;
  logic        rx_ack = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_available;
  logic        tx_ack = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        boot_valid;
  logic [31:0] boot_addr;
  logic        busy;

  uart_loader dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_pop(rx_pop), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_available(tx_available), .tx_ack(tx_ack),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .boot_valid(boot_valid), .boot_addr(boot_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  rx_q[$];
  logic [31:0] exp_maddr[$], exp_mdata[$], exp_boot[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] act_maddr[$], act_mdata[$], act_boot[$];
  logic [7:0]  act_tx[$];
  logic [31:0] wq[$];
  int vectors = 0;
  int miscompares = 0;
  int mem_hold = 0;
  int tx_hold = 0;
  bit rx_gaps = 1'b0;
`ifdef UART_LOADER_CKSUM_EN
  bit bad_cksum = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_resp();
`ifdef UART_LOADER_CKSUM_EN
    return bad_cksum ? RESP_NAK : RESP_ACK;
`else
    return RESP_ACK;
`endif
  endfunction

  // Append the frame (plus checksum when enabled) to the RX FIFO.
  task automatic commit(input logic [7:0] f[$]);
`ifdef UART_LOADER_CKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i < f.size(); i++) s = 8'(s + f[i]);
    f.push_back(bad_cksum ? 8'(s + 8'd1) : s);
`endif
    foreach (f[i]) rx_q.push_back(f[i]);
  endtask

  task automatic send_write(input logic [31:0] addr, input int n);
    logic [7:0]  f[$];
    logic [31:0] a, w;
    f.push_back(CMD_WRITE);
    for (int k = 0; k < 4; k++) f.push_back(addr[8*k +: 8]);
    f.push_back(8'(n));
    a = {addr[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      for (int k = 0; k < 4; k++) f.push_back(w[8*k +: 8]);
      exp_maddr.push_back(a);
      exp_mdata.push_back(w);
      a = a + 32'd4;
    end
    exp_tx.push_back(exp_resp());
    commit(f);
  endtask

  task automatic send_jump(input logic [31:0] addr);
    logic [7:0] f[$];
    f.push_back(CMD_JUMP);
    for (int k = 0; k < 4; k++) f.push_back(addr[8*k +: 8]);
    exp_tx.push_back(exp_resp());
    if (exp_resp() == RESP_ACK) exp_boot.push_back({addr[31:2], 2'b00});
    commit(f);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(rx_q.size() == 0 && exp_maddr.size() == 0 && exp_tx.size() == 0 &&
                           exp_boot.size() == 0 && !busy && !tx_available)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
    if (n >= budget) begin
      rx_q.delete(); exp_maddr.delete(); exp_mdata.delete(); exp_tx.delete(); exp_boot.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_pop"},       32'(rx_pop), 32'd0);
    check({tag, "_tx_available"}, 32'(tx_available), 32'd0);
    check({tag, "_tx_data"},      32'(tx_data), 32'd0);
    check({tag, "_mem_valid"},    32'(mem_valid), 32'd0);
    check({tag, "_mem_addr"},     mem_addr, 32'd0);
    check({tag, "_mem_wdata"},    mem_wdata, 32'd0);
    check({tag, "_boot_valid"},   32'(boot_valid), 32'd0);
    check({tag, "_boot_addr"},    boot_addr, 32'd0);
    check({tag, "_busy"},         32'(busy), 32'd0);
  endtask

  // Environment: RX FIFO answering pops one cycle later, memory and TX sinks.
  initial begin
    bit pend;
    forever begin
      @(negedge clk);
      pend = rx_pop && rst_n;
      @(posedge clk);
      #1;
      rx_ack = 1'b0;
      if (pend && rst_n && rx_q.size() > 0 && !(rx_gaps && $urandom_range(0, 2) == 0)) begin
        rx_ack  = 1'b1;
        rx_data = rx_q.pop_front();
      end
      if (mem_valid && mem_hold > 0) begin
        mem_ready = 1'b0;
        mem_hold--;
      end else begin
        mem_ready = 1'b1;
      end
      if (tx_available && tx_hold > 0) begin
        tx_ack = 1'b0;
        tx_hold--;
      end else begin
        tx_ack = tx_available;
      end
    end
  end

  // Compare process: every handshake and pulse against the expectation queues.
  initial begin
    bit prev_pop, prev_boot, mhold, thold;
    logic [31:0] ma_s, md_s;
    logic [7:0]  td_s;
    prev_pop = 0; prev_boot = 0; mhold = 0; thold = 0;
    ma_s = '0; md_s = '0; td_s = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pop = 0; prev_boot = 0; mhold = 0; thold = 0;
      end else begin
        if (rx_pop) check("pop_spacing", 32'(prev_pop), 32'd0);
        prev_pop = rx_pop;
        if (mhold) begin
          check("mem_hold_valid", 32'(mem_valid), 32'd1);
          check("mem_hold_addr", mem_addr, ma_s);
          check("mem_hold_wdata", mem_wdata, md_s);
        end
        mhold = mem_valid && !mem_ready; ma_s = mem_addr; md_s = mem_wdata;
        if (thold) begin
          check("tx_hold_avail", 32'(tx_available), 32'd1);
          check("tx_hold_data", 32'(tx_data), 32'(td_s));
        end
        thold = tx_available && !tx_ack; td_s = tx_data;
        if (mem_valid && mem_ready) begin
          act_maddr.push_back(mem_addr);
          act_mdata.push_back(mem_wdata);
          if (exp_maddr.size() == 0) begin
            check("mem_write_expected", 32'd1, 32'd0);
          end else begin
            check("mem_addr", mem_addr, exp_maddr.pop_front());
            check("mem_wdata", mem_wdata, exp_mdata.pop_front());
          end
        end
        if (tx_available && tx_ack) begin
          act_tx.push_back(tx_data);
          if (exp_tx.size() == 0) check("tx_expected", 32'd1, 32'd0);
          else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (boot_valid) begin
          act_boot.push_back(boot_addr);
          check("boot_pulse_width", 32'(prev_boot), 32'd0);
          if (exp_boot.size() == 0) check("boot_expected", 32'd1, 32'd0);
          else check("boot_addr", boot_addr, exp_boot.pop_front());
        end
        prev_boot = boot_valid;
      end
    end
  end

  initial begin
    int bm, bt, bb, n;
    logic [7:0] f[$];
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic WRITE, unaligned address
    bm = act_maddr.size(); bt = act_tx.size();
    wq = '{32'hDEADBEEF, 32'h01234567};
    send_write(32'h0000_1003, 2);
    wait_idle(400, "t1");
    check("t1_addr0", act_maddr[bm], 32'h0000_1000);
    check("t1_data0", act_mdata[bm], 32'hDEADBEEF);
    check("t1_addr1", act_maddr[bm+1], 32'h0000_1004);
    check("t1_data1", act_mdata[bm+1], 32'h0123_4567);
    check("t1_resp", 32'(act_tx[bt]), 32'h06);

`ifdef UART_LOADER_CKSUM_EN
    // Bad checksum: writes still land, NAK returned
    bm = act_maddr.size(); bt = act_tx.size();
    bad_cksum = 1'b1;
    send_write(32'h0000_1003, 2);
    wait_idle(400, "t2");
    bad_cksum = 1'b0;
    check("t2_writes", 32'(act_maddr.size() - bm), 32'd2);
    check("t2_resp", 32'(act_tx[bt]), 32'h15);
`endif

    // JUMP accepted
    bb = act_boot.size(); bt = act_tx.size();
    send_jump(32'h8000_0000);
    wait_idle(200, "t3");
    check("t3_boot_cnt", 32'(act_boot.size() - bb), 32'd1);
    check("t3_boot_addr", boot_addr, 32'h8000_0000);
    check("t3_resp", 32'(act_tx[bt]), 32'h06);

`ifdef UART_LOADER_CKSUM_EN
    // JUMP with bad checksum is not taken
    bb = act_boot.size(); bt = act_tx.size();
    bad_cksum = 1'b1;
    send_jump(32'h1234_5678);
    wait_idle(200, "t4");
    bad_cksum = 1'b0;
    check("t4_boot_cnt", 32'(act_boot.size() - bb), 32'd0);
    check("t4_boot_hold", boot_addr, 32'h8000_0000);
    check("t4_resp", 32'(act_tx[bt]), 32'h15);
`endif

    // Unknown command byte, then a normal frame
    bt = act_tx.size(); bm = act_maddr.size();
    rx_q.push_back(8'h00);
    exp_tx.push_back(RESP_UNK);
    wq = '{32'hA5A5_5A5A};
    send_write(32'h0000_0040, 1);
    wait_idle(300, "t5");
    check("t5_unk", 32'(act_tx[bt]), 32'h3F);
    check("t5_resp", 32'(act_tx[bt+1]), 32'h06);
    check("t5_addr", act_maddr[bm], 32'h0000_0040);

    // Back-pressure on every interface
    bm = act_maddr.size();
    mem_hold = 10; tx_hold = 5; rx_gaps = 1'b1;
    wq = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    send_write(32'h0000_0200, 3);
    wait_idle(2000, "t6");
    rx_gaps = 1'b0;
    check("t6_writes", 32'(act_maddr.size() - bm), 32'd3);
    check("t6_last_addr", act_maddr[bm+2], 32'h0000_0208);

    // Count 0 means 256 words; address wraps to the top of memory
    bm = act_maddr.size();
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(32'hC000_0000 | 32'(i * 3));
    send_write(32'hFFFF_FC00, 256);
    wait_idle(4000, "t7");
    n = act_maddr.size() - bm;
    check("t7_writes", 32'(n), 32'd256);
    check("t7_first_addr", act_maddr[bm], 32'hFFFF_FC00);
    check("t7_last_addr", act_maddr[act_maddr.size()-1], 32'hFFFF_FFFC);

    // Reset in the middle of a data word
    bt = act_tx.size();
    wq = '{32'hCAFE_F00D, 32'h7788_99AA};
    f = '{CMD_WRITE, 8'h00, 8'h20, 8'h00, 8'h00, 8'h04};
    for (int i = 0; i < 6; i++) f.push_back(wq[i/4][8*(i%4) +: 8]);
    exp_maddr.push_back(32'h0000_2000);
    exp_mdata.push_back(32'hCAFE_F00D);
    foreach (f[i]) rx_q.push_back(f[i]);
    n = 0;
    while (n < 300 && (rx_q.size() != 0 || exp_maddr.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    check("t8_partial_consumed", 32'(n < 300), 32'd1);
    repeat (6) @(negedge clk);
    check("t8_busy_mid", 32'(busy), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t8_no_resp", 32'(act_tx.size()), 32'(bt));
    check("t8_idle", 32'(busy), 32'd0);

    // Normal operation after reset
    bm = act_maddr.size(); bt = act_tx.size();
    wq = '{32'h0BAD_C0DE};
    send_write(32'h0000_3001, 1);
    wait_idle(300, "t9");
    check("t9_addr", act_maddr[bm], 32'h0000_3000);
    check("t9_data", act_mdata[bm], 32'h0BAD_C0DE);
    check("t9_resp", 32'(act_tx[bt]), 32'h06);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
